// File: rtl/kbd_fifo_if.sv
// Handshake/data bundle between the keyboard scancode FIFO and its port controller.
// The master side produces the scancode strobes and controller pulses; the slave side is the FIFO.
interface kbd_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          ps2_data;
    logic                ps2_hit;
    logic                rd;
    logic                ack;
    logic                clr;
    logic [7:0]          q;
    logic [DEPTH_LOG2:0] count;
    logic                empty;
    logic                full;
    logic                overflow;
    logic                irq;

    modport master (
        output ps2_data, ps2_hit, rd, ack, clr,
        input  q, count, empty, full, overflow, irq
    );

    modport slave (
        input  ps2_data, ps2_hit, rd, ack, clr,
        output q, count, empty, full, overflow, irq
    );
endinterface

// File: rtl/kbd_fifo.sv
// Keyboard scancode FIFO (circular buffer + count) with a level IRQ handshake FSM.
// Optional KBD_FIFO_OVERRUN_MARK_EN: a byte arriving while full replaces the newest entry with 8'hFF.
module kbd_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clock,
    input  logic       reset,
    kbd_fifo_if.slave  bus
);
    localparam int                      DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0]   PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]     CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]     CNT_ZERO = '0;
    localparam logic [DEPTH_LOG2:0]     CNT_FULL = CNT_ONE << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_PEND   = 2'd1,
        IRQ_SERVED = 2'd2
    } irq_state_e;

    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [7:0]            q_r;
    logic                  empty_r;
    logic                  full_r;
    logic                  overflow_r;
    logic                  irq_r;
    irq_state_e            irq_state_r;

    logic                  do_wr_s;
    logic                  do_rd_s;
    logic                  lost_s;
    logic                  mem_we_s;
    logic [DEPTH_LOG2-1:0] wr_addr_s;
    logic [7:0]            wr_byte_s;
    logic [DEPTH_LOG2-1:0] wr_ptr_nxt_s;
    logic [DEPTH_LOG2-1:0] rd_ptr_nxt_s;
    logic [DEPTH_LOG2:0]   count_nxt_s;
    logic [7:0]            q_nxt_s;

    // Next-state datapath: accepted push/pop, storage write port and the next head byte.
    always_comb begin
        do_rd_s      = bus.rd & ~empty_r;
        do_wr_s      = bus.ps2_hit & (~full_r | bus.rd);
        lost_s       = bus.ps2_hit & full_r & ~bus.rd;
        wr_ptr_nxt_s = do_wr_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nxt_s = do_rd_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

        if (do_wr_s && !do_rd_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (do_rd_s && !do_wr_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end

`ifdef KBD_FIFO_OVERRUN_MARK_EN
        mem_we_s  = do_wr_s | lost_s;
        wr_addr_s = do_wr_s ? wr_ptr_r : (wr_ptr_r - PTR_ONE);
        wr_byte_s = do_wr_s ? bus.ps2_data : 8'hFF;
`else
        mem_we_s  = do_wr_s;
        wr_addr_s = wr_ptr_r;
        wr_byte_s = bus.ps2_data;
`endif

        // The head may be the slot written on this same edge, so bypass the array then.
        if (count_nxt_s == CNT_ZERO) begin
            q_nxt_s = 8'h00;
        end else if (mem_we_s && (wr_addr_s == rd_ptr_nxt_s)) begin
            q_nxt_s = wr_byte_s;
        end else begin
            q_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array; deliberately not reset, q masks stale contents while empty.
    always_ff @(posedge clock) begin
        if (mem_we_s && !bus.clr) begin
            mem_r[wr_addr_s] <= wr_byte_s;
        end
    end

    // Pointers, count, status flags and registered head byte; clr acts as synchronous flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= CNT_ZERO;
            q_r        <= 8'h00;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= CNT_ZERO;
            q_r        <= 8'h00;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            q_r        <= q_nxt_s;
            empty_r    <= (count_nxt_s == CNT_ZERO);
            full_r     <= (count_nxt_s == CNT_FULL);
            overflow_r <= overflow_r | lost_s;
        end
    end

    // IRQ handshake FSM; irq is high exactly while in PEND.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_state_r <= IRQ_IDLE;
            irq_r       <= 1'b0;
        end else if (bus.clr) begin
            irq_state_r <= IRQ_IDLE;
            irq_r       <= 1'b0;
        end else begin
            case (irq_state_r)
                IRQ_IDLE: begin
                    if (count_r != CNT_ZERO) begin
                        irq_state_r <= IRQ_PEND;
                        irq_r       <= 1'b1;
                    end else begin
                        irq_state_r <= IRQ_IDLE;
                        irq_r       <= 1'b0;
                    end
                end
                IRQ_PEND: begin
                    if (bus.ack) begin
                        irq_state_r <= IRQ_SERVED;
                        irq_r       <= 1'b0;
                    end else begin
                        irq_state_r <= IRQ_PEND;
                        irq_r       <= 1'b1;
                    end
                end
                IRQ_SERVED: begin
                    if (bus.rd) begin
                        irq_state_r <= IRQ_IDLE;
                    end else begin
                        irq_state_r <= IRQ_SERVED;
                    end
                    irq_r <= 1'b0;
                end
                default: begin
                    irq_state_r <= IRQ_IDLE;
                    irq_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q        = q_r;
    assign bus.count    = count_r;
    assign bus.empty    = empty_r;
    assign bus.full     = full_r;
    assign bus.overflow = overflow_r;
    assign bus.irq      = irq_r;
endmodule

// File: tb/tb_kbd_fifo.sv
// Scoreboard bench for kbd_fifo: a queue-based reference model predicts outputs per edge,
// a monitor compares them one cycle at a time.
module tb_kbd_fifo;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int ST_IDLE = 0, ST_PEND = 1, ST_SERVED = 2;

    typedef struct packed {
        logic [7:0]  q;
        logic [DL:0] count;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        irq;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    int         m_st  = ST_IDLE;

    kbd_fifo_if #(.DEPTH_LOG2(DL)) bus();
    kbd_fifo #(.DEPTH_LOG2(DL)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #10 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.q     = (mq.size() != 0) ? mq[0] : 8'h00;
        e.count = (DL + 1)'(mq.size());
        e.empty = (mq.size() == 0);
        e.full  = (mq.size() == DEPTH);
        e.ovf   = m_ovf;
        e.irq   = (m_st == ST_PEND);
        return e;
    endfunction

    // One clock edge of the reference model, applied in behavioural order.
    task automatic model_edge(input logic h, input logic [7:0] d, input logic r,
                              input logic a, input logic c);
        int  sz;
        bit  was_full;
        sz = mq.size();
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_st  = ST_IDLE;
        end else begin
            if (m_st == ST_IDLE && sz != 0)      m_st = ST_PEND;
            else if (m_st == ST_PEND && a)       m_st = ST_SERVED;
            else if (m_st == ST_SERVED && r)     m_st = ST_IDLE;
            was_full = (sz == DEPTH);
            if (r && sz != 0) void'(mq.pop_front());
            if (h) begin
                if (!was_full || r) begin
                    mq.push_back(d);
                end else begin
                    m_ovf = 1'b1;
`ifdef KBD_FIFO_OVERRUN_MARK_EN
                    mq[mq.size() - 1] = 8'hFF;
`endif
                end
            end
        end
    endtask

    task automatic step(input logic h, input logic [7:0] d, input logic r,
                        input logic a, input logic c);
        @(negedge clock);
        bus.ps2_hit  = h;
        bus.ps2_data = d;
        bus.rd       = r;
        bus.ack      = a;
        bus.clr      = c;
        model_edge(h, d, r, a, c);
        exp_q.push_back(model_outputs());
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_drained();
        @(posedge clock);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every edge with a pending expectation is compared against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("q",        32'(bus.q),        32'(e.q));
                check("count",    32'(bus.count),    32'(e.count));
                check("empty",    32'(bus.empty),    32'(e.empty));
                check("full",     32'(bus.full),     32'(e.full));
                check("overflow", 32'(bus.overflow), 32'(e.ovf));
                check("irq",      32'(bus.irq),      32'(e.irq));
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        int hp, rp;
        bus.ps2_hit = 1'b0; bus.ps2_data = 8'h00; bus.rd = 1'b0; bus.ack = 1'b0; bus.clr = 1'b0;
        #25;
        check("rst_q",     32'(bus.q),        32'h00);
        check("rst_count", 32'(bus.count),    32'd0);
        check("rst_empty", 32'(bus.empty),    32'd1);
        check("rst_full",  32'(bus.full),     32'd0);
        check("rst_ovf",   32'(bus.overflow), 32'd0);
        check("rst_irq",   32'(bus.irq),      32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single byte, irq two edges after the strobe.
        step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Make/break sequence with ack then rd; irq re-raises.
        step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Overflow with 17 bytes, then drain.
        for (int i = 1; i <= 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Full plus simultaneous hit/rd, then drain to see wrapped order.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Hit+rd while empty, then clr beats a simultaneous hit.
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Asynchronous reset in the middle of a fill.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        idle(2);
        wait_drained();
        check("pre_rst_irq", 32'(bus.irq), 32'(m_st == ST_PEND));
        reset = 1'b1;
        #1;
        check("mid_rst_count", 32'(bus.count),    32'd0);
        check("mid_rst_empty", 32'(bus.empty),    32'd1);
        check("mid_rst_irq",   32'(bus.irq),      32'd0);
        check("mid_rst_ovf",   32'(bus.overflow), 32'd0);
        check("mid_rst_q",     32'(bus.q),        32'h00);
        mq.delete();
        m_ovf = 1'b0;
        m_st  = ST_IDLE;
        @(negedge clock);
        reset = 1'b0;

        // Randomized traffic in fill / drain / balanced phases.
        for (int i = 0; i < 1500; i++) begin
            case ((i / 100) % 3)
                0:       begin hp = 80; rp = 10; end
                1:       begin hp = 15; rp = 60; end
                default: begin hp = 50; rp = 45; end
            endcase
            step(($urandom_range(99) < 32'(hp)), 8'($urandom),
                 ($urandom_range(99) < 32'(rp)),
                 ($urandom_range(99) < 32'd25),
                 ($urandom_range(149) == 32'd0));
        end
        idle(2);
        wait_drained();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
